// File: rtl/systolic_mac_array_pkg.sv
// rtl/systolic_mac_array_pkg.sv - shared enums and accumulator init helper for the systolic MAC array
package systolic_pkg;

   typedef enum logic [1:0] {
      MOD  = 2'd0,
      SAT  = 2'd1,
      MAXP = 2'd2,
      MINP = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Fill bit for the accumulator identity; callers replicate it to ACC_W.
   function automatic logic acc_init(mode_t m);
      return (m == MINP);
   endfunction

endpackage

// File: rtl/systolic_mac_array_if.sv
// rtl/systolic_mac_array_if.sv - operand/result handshake bundle for the systolic MAC array
interface systolic_mac_array_if #(
   parameter int N     = 4,
   parameter int W     = 4,
   parameter int ACC_W = 8
) ();
   localparam int RW = $clog2(N);

   logic                 start;
   logic [1:0]           mode;
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_last;
   logic [N*W-1:0]       a_in;
   logic [N*W-1:0]       b_in;
   logic                 res_valid;
   logic                 res_ready;
   logic [N*ACC_W-1:0]   res_data;
   logic [RW-1:0]        res_row;
   logic                 busy;
   logic                 done;

   modport master (
      output start, mode, in_valid, in_last, a_in, b_in, res_ready,
      input  in_ready, res_valid, res_data, res_row, busy, done
   );

   modport slave (
      input  start, mode, in_valid, in_last, a_in, b_in, res_ready,
      output in_ready, res_valid, res_data, res_row, busy, done
   );
endinterface

// File: rtl/systolic_mac_array_pe.sv
// rtl/systolic_mac_array_pe.sv - one processing element: A/B/valid forwarding plus semiring accumulator
module systolic_pe
   import systolic_pkg::*;
#(
   parameter int W     = 4,
   parameter int ACC_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             init_fill,
   input  mode_t            mode,
   input  logic [W-1:0]     a_in,
   input  logic [W-1:0]     b_in,
   input  logic             v_in,
   output logic [W-1:0]     a_out,
   output logic [W-1:0]     b_out,
   output logic             v_out,
   output logic [ACC_W-1:0] acc
);
   logic [2*W-1:0]   prod;
   logic [ACC_W:0]   mac_sum;
   logic [W:0]       add_ab_n;
   logic [ACC_W-1:0] add_ab;
   logic [ACC_W-1:0] acc_nx;

   assign prod     = {{W{1'b0}}, a_in} * {{W{1'b0}}, b_in};
   assign mac_sum  = {1'b0, acc} + (ACC_W + 1)'(prod);
   assign add_ab_n = {1'b0, a_in} + {1'b0, b_in};
   assign add_ab   = ACC_W'(add_ab_n);

   always_comb begin
      acc_nx = acc;
      unique case (mode)
         MOD:  acc_nx = mac_sum[ACC_W-1:0];
         SAT:  acc_nx = mac_sum[ACC_W] ? {ACC_W{1'b1}} : mac_sum[ACC_W-1:0];
         MAXP: acc_nx = (add_ab > acc) ? add_ab : acc;
         MINP: acc_nx = (add_ab < acc) ? add_ab : acc;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_out <= '0;
         b_out <= '0;
         v_out <= 1'b0;
         acc   <= '0;
      end else begin
         a_out <= a_in;
         b_out <= b_in;
         v_out <= v_in;
         if (clear) begin
            acc <= {ACC_W{init_fill}};
         end else if (v_in) begin
            acc <= acc_nx;
         end
      end
   end
endmodule

// File: rtl/systolic_mac_array.sv
// rtl/systolic_mac_array.sv - output-stationary NxN systolic matrix engine with selectable semiring
module systolic_mac_array
   import systolic_pkg::*;
#(
   parameter int N     = 4,
   parameter int W     = 4,
   parameter int ACC_W = 8
) (
   input logic                clk,
   input logic                reset,
   systolic_mac_array_if.slave bus
);
   localparam int RW = $clog2(N);
   localparam int FW = $clog2(2 * N);

   if (ACC_W < 2 * W) begin : g_bad_acc_w
      $error("systolic_mac_array: ACC_W must be at least 2*W");
   end
   if (N < 2) begin : g_bad_n
      $error("systolic_mac_array: N must be at least 2");
   end

   state_t         state, state_nx;
   mode_t          mode_q;
   logic [FW-1:0]  flush_cnt;
   logic [RW-1:0]  row_q;
   logic           done_q;
   logic           accept;
   logic           row_fire;
   logic           last_row;
   logic           job_clear;
   logic           init_fill;

   logic [W-1:0]     a_h [N][N+1];
   logic             v_h [N][N+1];
   logic [W-1:0]     b_v [N+1][N];
   logic [ACC_W-1:0] acc_q [N][N];

   assign accept    = bus.in_valid && (state == LOAD);
   assign row_fire  = (state == DRAIN) && bus.res_ready;
   assign last_row  = (row_q == RW'(N - 1));
   assign job_clear = (state == IDLE) && bus.start;
   assign init_fill = acc_init(mode_t'(bus.mode));

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (bus.start) state_nx = LOAD;
         LOAD:  if (accept && bus.in_last) state_nx = FLUSH;
         FLUSH: if (flush_cnt == FW'(2 * N - 2)) state_nx = DRAIN;
         DRAIN: if (row_fire && last_row) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mode_q    <= MOD;
         flush_cnt <= '0;
         row_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_nx;
         done_q    <= row_fire && last_row;
         flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
         if (job_clear) mode_q <= mode_t'(bus.mode);
         if (row_fire) row_q <= last_row ? '0 : row_q + RW'(1);
      end
   end

   // Row i of A and column j of B each sit behind i+1 / j+1 registers so that
   // a beat accepted at edge t reaches PE(i,j) for the update at edge t+i+j+1.
   for (genvar i = 0; i < N; i++) begin : g_a_skew
      logic [i:0][W-1:0] a_d;
      logic [i:0]        v_d;
      always_ff @(posedge clk) begin
         if (reset) begin
            a_d <= '0;
            v_d <= '0;
         end else begin
            a_d[0] <= bus.a_in[i*W +: W];
            v_d[0] <= accept;
            for (int d = 1; d <= i; d++) begin
               a_d[d] <= a_d[d-1];
               v_d[d] <= v_d[d-1];
            end
         end
      end
      assign a_h[i][0] = a_d[i];
      assign v_h[i][0] = v_d[i];
   end

   for (genvar j = 0; j < N; j++) begin : g_b_skew
      logic [j:0][W-1:0] b_d;
      always_ff @(posedge clk) begin
         if (reset) begin
            b_d <= '0;
         end else begin
            b_d[0] <= bus.b_in[j*W +: W];
            for (int d = 1; d <= j; d++) begin
               b_d[d] <= b_d[d-1];
            end
         end
      end
      assign b_v[0][j] = b_d[j];
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         systolic_pe #(
            .W     (W),
            .ACC_W (ACC_W)
         ) u_pe (
            .clk       (clk),
            .reset     (reset),
            .clear     (job_clear),
            .init_fill (init_fill),
            .mode      (mode_q),
            .a_in      (a_h[i][j]),
            .b_in      (b_v[i][j]),
            .v_in      (v_h[i][j]),
            .a_out     (a_h[i][j+1]),
            .b_out     (b_v[i+1][j]),
            .v_out     (v_h[i][j+1]),
            .acc       (acc_q[i][j])
         );
      end
   end

   always_comb begin
      bus.res_data = '0;
      if (state == DRAIN) begin
         for (int j = 0; j < N; j++) begin
            bus.res_data[j*ACC_W +: ACC_W] = acc_q[row_q][j];
         end
      end
   end

   assign bus.res_row   = row_q;
   assign bus.res_valid = (state == DRAIN);
   assign bus.in_ready  = (state == LOAD);
   assign bus.busy      = (state != IDLE);
   assign bus.done      = done_q;
endmodule

// File: tb/tb_systolic_mac_array.sv
// tb/tb_systolic_mac_array.sv - directed self-checking bench for systolic_mac_array
module tb_systolic_mac_array;
   localparam int N       = 2;
   localparam int W       = 4;
   localparam int ACC_W   = 8;
   localparam int ACC_MAX = (1 << ACC_W) - 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   systolic_mac_array_if #(.N(N), .W(W), .ACC_W(ACC_W)) bus ();

   systolic_mac_array #(.N(N), .W(W), .ACC_W(ACC_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc_cnt  = 0;

   int ja [4][N];
   int jb [4][N];
   int exp_c [N][N];
   int lit [N][N];
   logic [N*ACC_W-1:0] got [N];
   int rows_seen = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Plain matrix arithmetic over the stored beats.
   function automatic void model(input int md, input int k);
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            int acc;
            acc = (md == 3) ? ACC_MAX : 0;
            for (int kk = 0; kk < k; kk++) begin
               int p, s;
               p = ja[kk][r] * jb[kk][c];
               s = ja[kk][r] + jb[kk][c];
               case (md)
                  0: acc = (acc + p) % (ACC_MAX + 1);
                  1: acc = (acc + p > ACC_MAX) ? ACC_MAX : acc + p;
                  2: acc = (s > acc) ? s : acc;
                  default: acc = (s < acc) ? s : acc;
               endcase
            end
            exp_c[r][c] = acc;
         end
      end
   endfunction

   task automatic set_beat(input int kk, input int a0, input int a1, input int b0, input int b1);
      ja[kk][0] = a0; ja[kk][1] = a1;
      jb[kk][0] = b0; jb[kk][1] = b1;
   endtask

   task automatic set_lit(input int c00, input int c01, input int c10, input int c11);
      lit[0][0] = c00; lit[0][1] = c01;
      lit[1][0] = c10; lit[1][1] = c11;
   endtask

   // Compare process: every row presented is checked against the model,
   // stall stability and the done pulse are checked cycle by cycle.
   initial begin : compare
      int exp_row;
      logic done_exp, prev_stall;
      logic [N*ACC_W-1:0] prev_data;
      logic [$clog2(N)-1:0] prev_row;
      exp_row = 0; done_exp = 1'b0; prev_stall = 1'b0;
      prev_data = '0; prev_row = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_row = 0; done_exp = 1'b0; prev_stall = 1'b0;
         end else begin
            chk("done_pulse", bus.done, done_exp);
            if (done_exp) chk("busy_at_done", bus.busy, 1'b0);
            if (prev_stall) begin
               chk("stall_data_hold", bus.res_data, prev_data);
               chk("stall_row_hold", bus.res_row, prev_row);
            end
            if (bus.res_valid) begin
               logic [N*ACC_W-1:0] exp_vec;
               for (int j = 0; j < N; j++) exp_vec[j*ACC_W +: ACC_W] = ACC_W'(exp_c[exp_row][j]);
               chk("res_row", bus.res_row, exp_row);
               chk("res_data", bus.res_data, exp_vec);
            end
            done_exp   = bus.res_valid && bus.res_ready && (exp_row == N - 1);
            prev_stall = bus.res_valid && !bus.res_ready;
            prev_data  = bus.res_data;
            prev_row   = bus.res_row;
            if (bus.res_valid && bus.res_ready) begin
               got[exp_row] = bus.res_data;
               exp_row = (exp_row + 1) % N;
               rows_seen++;
            end
         end
      end
   end

   task automatic run_job(input string tag, input int md, input int k, input bit bub,
                          input bit stl, input bit fstart, input bit dval);
      int s, stalls, exp_lat;
      bit got_done;
      model(md, k);
      rows_seen = 0;
      stalls = 0;
      got_done = 1'b0;
      bus.res_ready = !stl;
      bus.mode  = 2'(md);
      bus.start = 1'b1;
      s = cyc_cnt;
      cyc();
      bus.start = 1'b0;
      for (int kk = 0; kk < k; kk++) begin
         if (bub && kk > 0) begin
            for (int b = 0; b < 3; b++) begin
               bus.in_valid = 1'b0;
               bus.in_last  = 1'b1;
               bus.a_in = ($urandom & ((1 << (N*W)) - 1));
               bus.b_in = ($urandom & ((1 << (N*W)) - 1));
               cyc();
            end
         end
         chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
         bus.in_valid = 1'b1;
         bus.in_last  = (kk == k - 1);
         for (int i = 0; i < N; i++) begin
            bus.a_in[i*W +: W] = W'(ja[kk][i]);
            bus.b_in[i*W +: W] = W'(jb[kk][i]);
         end
         cyc();
      end
      bus.in_valid = dval;
      bus.in_last  = dval;
      bus.a_in = '1;
      bus.b_in = '1;
      if (fstart) begin
         bus.start = 1'b1;
         bus.mode  = 2'(~md);
         cyc();
         bus.start = 1'b0;
      end
      for (int i = 0; i < 200 && !got_done; i++) begin
         if (stl && bus.res_valid && stalls < 3) begin
            bus.res_ready = 1'b0;
            stalls++;
         end else begin
            bus.res_ready = 1'b1;
         end
         cyc();
         if (bus.done) got_done = 1'b1;
      end
      chk({tag, "_done_seen"}, got_done, 1'b1);
      exp_lat = k + 3*N + 1 + (bub ? 3*(k-1) : 0) + (stl ? 3 : 0);
      chk({tag, "_latency"}, cyc_cnt - s + 1, exp_lat);
      chk({tag, "_rows_seen"}, rows_seen, N);
      chk({tag, "_in_ready_idle"}, bus.in_ready, 1'b0);
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            chk({tag, "_model_pin"}, exp_c[r][c], lit[r][c]);
            chk({tag, "_dut_pin"}, got[r][c*ACC_W +: ACC_W], lit[r][c]);
         end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      cyc();
   endtask

   initial begin
      bus.start = 1'b0; bus.mode = 2'd0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
      bus.a_in = '0; bus.b_in = '0; bus.res_ready = 1'b1;
      reset = 1'b1;
      cyc(); cyc(); cyc();
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_res_valid", bus.res_valid, 1'b0);
      chk("rst_res_data", bus.res_data, '0);
      chk("rst_res_row", bus.res_row, '0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      reset = 1'b0;
      cyc();

      set_beat(0, 1, 3, 5, 6); set_beat(1, 2, 4, 7, 8);
      set_lit(19, 22, 43, 50);
      run_job("mod_basic", 0, 2, 0, 0, 0, 0);

      set_beat(0, 15, 15, 15, 15); set_beat(1, 15, 15, 15, 15);
      set_lit(194, 194, 194, 194);
      run_job("mod_wrap", 0, 2, 0, 0, 0, 0);
      set_lit(255, 255, 255, 255);
      run_job("sat", 1, 2, 0, 0, 0, 0);

      set_beat(0, 1, 3, 4, 0); set_beat(1, 9, 2, 1, 5);
      set_lit(10, 14, 7, 7);
      run_job("maxp", 2, 2, 0, 0, 0, 0);
      set_lit(5, 1, 3, 3);
      run_job("minp", 3, 2, 0, 0, 0, 0);

      set_beat(0, 1, 3, 5, 6); set_beat(1, 2, 4, 7, 8);
      set_lit(19, 22, 43, 50);
      run_job("bubble_stall", 0, 2, 1, 1, 0, 0);

      bus.mode = 2'd0; bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      bus.in_valid = 1'b1; bus.in_last = 1'b0; bus.a_in = '1; bus.b_in = '1;
      cyc();
      bus.in_valid = 1'b0;
      reset = 1'b1;
      cyc(); cyc();
      chk("midrst_busy", bus.busy, 1'b0);
      chk("midrst_in_ready", bus.in_ready, 1'b0);
      chk("midrst_done", bus.done, 1'b0);
      reset = 1'b0;
      cyc();
      set_beat(0, 1, 0, 2, 3); set_beat(1, 0, 1, 4, 5);
      set_lit(2, 3, 4, 5);
      run_job("after_reset", 0, 2, 0, 0, 0, 0);

      set_beat(0, 1, 3, 5, 6); set_beat(1, 2, 4, 7, 8);
      set_lit(19, 22, 43, 50);
      run_job("ignored_ctl", 0, 2, 0, 0, 1, 1);

      cyc(); cyc();
      chk("final_idle_busy", bus.busy, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/systolic_mac_array.md
# systolic_mac_array

Parametrised output-stationary N×N systolic matrix-multiply engine with a selectable accumulate semiring: modular, saturating, max-plus or min-plus. It generalises the single-bit registered systolic cells into multi-bit processing elements with internal input skewing, a load/flush/drain state machine and valid/ready streaming on both sides. It sits between the top-level pin-muxing logic, which serialises operands onto `in_*`, and the result readout path on `res_*`.

## Interface
- `N`, 4, array dimension (rows = columns); N ≥ 2
- `W`, 4, operand element width
- `ACC_W`, 8, accumulator width; must be ≥ 2·W (elaboration error otherwise)

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a job; sampled only in IDLE
- `mode`  in  2  0 modular MAC, 1 saturating MAC, 2 max-plus, 3 min-plus; latched on accepted `start`
- `in_valid`  in  1  operand beat valid
- `in_ready`  out  1  high exactly in LOAD
- `in_last`  in  1  marks final beat of the job
- `a_in`  in  N·W  column k of A; element i at bits [i·W +: W]
- `b_in`  in  N·W  row k of B; element j at bits [j·W +: W]
- `res_valid`  out  1  result row valid
- `res_ready`  in  1  consumer accepts result row
- `res_data`  out  N·ACC_W  row r of C; element j at bits [j·ACC_W +: ACC_W]
- `res_row`  out  $clog2(N)  index r of current row
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse at job end

## Operation
- FSM: IDLE → LOAD on `start`; LOAD → FLUSH on accepted beat with `in_last`; FLUSH → DRAIN after 2N−1 cycles; DRAIN → IDLE after N accepted rows.
- On `start` in IDLE: latch `mode`; clear every accumulator to its mode's init value: 0 for modes 0/1/2, all-ones for mode 3.
- LOAD: beat accepted when `in_valid && in_ready`. Bubbles (`in_valid` low) are allowed anywhere and do not affect results. A valid tag travels with each beat.
- Skew: `a_in` element i is delayed i cycles and enters row i; `b_in` element j is delayed j cycles and enters column j. A moves right and B moves down, one register per PE. The valid tag moves with A.
- PE(i,j), on valid tag only:
  - mode 0: acc ← (acc + a·b) mod 2^ACC_W
  - mode 1: acc ← min(acc + a·b, 2^ACC_W−1), computed at ACC_W+1 bits
  - mode 2: acc ← max(acc, a+b)
  - mode 3: acc ← min(acc, a+b)
  - a+b is W+1 bits, zero-extended to ACC_W; all arithmetic is unsigned.
- DRAIN: rows are presented in order r = 0..N−1. `res_data` and `res_row` stay stable while `res_valid && !res_ready`.
- K (beat count) is unbounded; modes 0/1 wrap or saturate accordingly.
- `start` outside IDLE is ignored. `in_valid` outside LOAD is ignored.
- Reset mid-job: immediate return to IDLE; all state, skew registers and accumulators cleared to 0; no `done` pulse.

## Timing
- Reset values: `in_ready`=0, `res_valid`=0, `res_data`=0, `res_row`=0, `busy`=0, `done`=0.
- `start` accepted at edge t: `in_ready` is high from cycle t+1.
- Beat accepted at edge t updates PE(i,j) at edge t+i+j+1.
- FLUSH lasts 2N−1 cycles. `res_valid` for row 0 rises on the first DRAIN cycle.
- Drain throughput is one row per cycle while `res_ready` is held high.
- `done` pulses in the cycle after the final row handshake; `busy` is low in that same cycle.
- Minimum job latency (K beats, no bubbles, `res_ready`=1): start→done = 1 + K + (2N−1) + N + 1 cycles.

## Structure
- Shared package `systolic_pkg`:
  - `mode_t` enum (MOD, SAT, MAXP, MINP)
  - `state_t` enum (IDLE, LOAD, FLUSH, DRAIN)
  - function `acc_init(mode_t)`
- Sub-module `systolic_pe`: one-cycle A/B/valid forwarding registers plus the mode-selected accumulator. It is instantiated N² times in generate loops.
- Skew delay lines, FSM, flush counter and drain row mux live in the top module.

## Test plan
All scenarios use N=2, W=4, ACC_W=8.
- Mode 0: beats a=(1,3) b=(5,6), then a=(2,4) b=(7,8) with `in_last` → rows [19,22], [43,50]; then `done` pulses.
- Modes 0 and 1 with all operands 15, K=2 → mode 0 gives every element 194; mode 1 gives every element 255.
- Mode 2: A=[[1,9],[3,2]], B=[[4,0],[1,5]] → rows [10,14], [7,7]. Mode 3 with the same operands → rows [5,1], [3,3].
- First scenario with 3 bubble cycles between beats and `res_ready` low for 3 cycles on row 0 → identical results; `res_data` held stable during the stall; no row lost or duplicated.
- `reset` asserted mid-LOAD, then a new mode-0 job with identity A and B=[[2,3],[4,5]] → rows [2,3], [4,5]; no `done` pulse from the aborted job.
- `start` pulsed during FLUSH and `in_valid` held high in DRAIN → ignored; results and timing unchanged.
